bus_hold_arbiter: RTL and testbench
===================================

Name: bus_hold_arbiter

Overview:
- Shares the 8088 system bus among up to NUM_REQ external masters (blitter, DSP, video fetch) using the CPU bus interface's HOLD/HOLDA handshake.
- Requests HOLD from the CPU, waits for HOLDA, then grants the bus to one master at a time.
- Enforces a burst limit, a chaining limit and a guaranteed CPU slot between hold periods so the CPU and its prefetch queue are never starved.

Parameters:
- NUM_REQ, 3, number of requesting masters (2..8).
- MAX_BURST, 16, max CLK cycles one grant may last.
- MAX_CHAIN, 2, max back-to-back grants within one HOLD period.
- CPU_SLOT, 8, min CLK cycles with HOLD=0 after HOLDA falls, before HOLD may be raised again.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET_n  in  1  asynchronous active-low reset.
- REQ  in  NUM_REQ  level request per master; held while the bus is wanted.
- HOLDA  in  1  hold acknowledge from CPU bus interface, synchronous to CLK.
- HOLD  out  1  hold request to CPU bus interface.
- GNT  out  NUM_REQ  one-hot grant, registered.
- GNT_ID  out  clog2(NUM_REQ)  index of current/last owner.
- BUSY  out  1  high in any state other than IDLE.
- PROTO_ERR  out  1  one-cycle pulse when HOLDA drops during GRANT.

Behaviour:
- Reset (async, RESET_n=0): state IDLE; HOLD=0, GNT=0, GNT_ID=0, BUSY=0, PROTO_ERR=0; burst_cnt, chain_cnt, slot_cnt and rr_ptr all 0. Reset mid-grant drops HOLD and GNT immediately, without waiting for a clock edge.
- States: IDLE, HOLD_WAIT, GRANT, TURN, RELEASE, CPU_GAP.
- IDLE: if any REQ is high, HOLD<=1 and go to HOLD_WAIT.
- HOLD_WAIT:
  - If HOLDA=1 and any REQ is high: select winner; GNT<=onehot(winner), GNT_ID<=winner, burst_cnt<=0, chain_cnt<=1, go to GRANT. Latency from HOLDA rising to GNT is 1 CLK.
  - If no REQ is high and HOLDA=0: HOLD<=0, go to IDLE.
  - If no REQ is high and HOLDA=1: HOLD<=0, go to RELEASE.
- Winner selection: fixed priority, lowest index wins (see Optional Feature).
- GRANT:
  - burst_cnt increments each cycle.
  - If REQ[GNT_ID]=0 or burst_cnt=MAX_BURST-1: GNT<=0, go to TURN. A grant therefore lasts at most MAX_BURST cycles.
  - If HOLDA=0 (takes precedence over the above): GNT<=0, PROTO_ERR<=1 for one cycle, HOLD<=0, go to CPU_GAP with slot_cnt<=0.
- TURN (1 cycle, HOLD stays 1, GNT=0):
  - If any REQ is high and chain_cnt<MAX_CHAIN: select winner, regrant, chain_cnt++, burst_cnt<=0, go to GRANT.
  - Otherwise: HOLD<=0, go to RELEASE.
  - A revoked master still holding REQ is eligible here as a normal requester.
- RELEASE: wait for HOLDA=0, then slot_cnt<=0 and go to CPU_GAP. There is no timeout.
- CPU_GAP: HOLD=0; slot_cnt increments; at slot_cnt=CPU_SLOT-1 go to IDLE. A pending REQ raises HOLD no earlier than CPU_SLOT+1 cycles after HOLDA fell.
- Simultaneous events:
  - HOLDA falling in the same cycle as owner release is a PROTO_ERR (GRANT check wins).
  - REQ toggling inside one cycle is ignored; only the level at the clock edge is sampled.
- Counters: saturating width clog2(MAX_BURST+1), no wrap.
- GNT is never multi-hot. GNT is nonzero only in GRANT and only while HOLD=1.

Optional Feature:
- Macro BUS_HOLD_ARB_ROUND_ROBIN_EN.
- Defined: round-robin selection. Search starts at rr_ptr. On each grant rr_ptr<=winner+1, wrapping at NUM_REQ to 0.
- Undefined: fixed priority (index 0 highest); rr_ptr is absent.

Test Plan:
- REQ=3'b001, HOLDA rises 3 cycles after HOLD -> GNT=001 one cycle after HOLDA; REQ drops -> GNT=0 next cycle, TURN, HOLD=0, HOLDA falls -> HOLD held 0 for 8 cycles.
- REQ=3'b011 held forever, fixed priority -> GNT=001 for exactly 16 cycles, TURN, GNT=001 again (chain 2), then HOLD=0; master 1 is never served until after CPU_GAP.
- Same stimulus with BUS_HOLD_ARB_ROUND_ROBIN_EN -> grant sequence 001, 010 across the chain; next HOLD period starts with 001.
- REQ=3'b100 raised then dropped before HOLDA -> HOLD returns to 0; GNT never asserted; state IDLE.
- In GRANT, force HOLDA=0 -> PROTO_ERR one-cycle pulse, GNT=0 and HOLD=0 next cycle.
- RESET_n pulsed low mid-GRANT between clock edges -> HOLD=0, GNT=0 immediately; after release, REQ=001 restarts at HOLD_WAIT.

Source files
------------

// File: rtl/bus_hold_arbiter.sv
// HOLD/HOLDA arbiter sharing the 8088 bus among NUM_REQ masters with burst, chain and CPU-slot limits.
// Define BUS_HOLD_ARB_ROUND_ROBIN_EN for round-robin selection; fixed priority (index 0 highest) otherwise.
module bus_hold_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int MAX_BURST = 16,
    parameter int MAX_CHAIN = 2,
    parameter int CPU_SLOT  = 8
) (
    input  logic                       CLK,
    input  logic                       RESET_n,
    input  logic [NUM_REQ-1:0]         REQ,
    input  logic                       HOLDA,
    output logic                       HOLD,
    output logic [NUM_REQ-1:0]         GNT,
    output logic [$clog2(NUM_REQ)-1:0] GNT_ID,
    output logic                       BUSY,
    output logic                       PROTO_ERR
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HOLD_WAIT = 3'd1,
        ST_GRANT     = 3'd2,
        ST_TURN      = 3'd3,
        ST_RELEASE   = 3'd4,
        ST_CPU_GAP   = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic                 hold_q, hold_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
    logic                 busy_q, busy_d;
    logic                 proto_err_q, proto_err_d;
    logic [CNT_W-1:0]     burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0]     chain_cnt_q, chain_cnt_d;
    logic [CNT_W-1:0]     slot_cnt_q, slot_cnt_d;
    logic                 any_req_s, owner_req_s, grant_start_s;
    logic [ID_W-1:0]      winner_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) sat_inc = v;
        else              sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // First requester found when scanning upward from start, wrapping at NUM_REQ.
    function automatic logic [ID_W-1:0] pick_winner(input logic [NUM_REQ-1:0] req, input int start);
        logic               found;
        logic [NUM_REQ-1:0] sh;
        int                 idx;
        pick_winner = {ID_W{1'b0}};
        found       = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = start + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            sh = req >> idx;
            if (!found && sh[0]) begin
                pick_winner = ID_W'(idx);
                found       = 1'b1;
            end
        end
    endfunction

`ifdef BUS_HOLD_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    assign winner_s = pick_winner(REQ, int'(rr_ptr_q));

    // Round-robin pointer moves past each new winner.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_start_s) begin
            if (winner_s == ID_W'(NUM_REQ - 1)) rr_ptr_d = {ID_W{1'b0}};
            else                                rr_ptr_d = winner_s + {{(ID_W-1){1'b0}}, 1'b1};
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) rr_ptr_q <= {ID_W{1'b0}};
        else          rr_ptr_q <= rr_ptr_d;
    end
`else
    assign winner_s = pick_winner(REQ, 0);
`endif

    assign any_req_s     = |REQ;
    assign owner_req_s   = |(REQ & gnt_q);
    assign grant_start_s = (state_d == ST_GRANT) && (state_q != ST_GRANT);

    // State and registered outputs.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= 1'b0;
            gnt_q       <= {NUM_REQ{1'b0}};
            gnt_id_q    <= {ID_W{1'b0}};
            busy_q      <= 1'b0;
            proto_err_q <= 1'b0;
            burst_cnt_q <= {CNT_W{1'b0}};
            chain_cnt_q <= {CNT_W{1'b0}};
            slot_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            busy_q      <= busy_d;
            proto_err_q <= proto_err_d;
            burst_cnt_q <= burst_cnt_d;
            chain_cnt_q <= chain_cnt_d;
            slot_cnt_q  <= slot_cnt_d;
        end
    end

    // Next-state logic; loss of HOLDA during a grant overrides owner release.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) state_d = ST_HOLD_WAIT;
                else           state_d = ST_IDLE;
            end
            ST_HOLD_WAIT: begin
                if (HOLDA && any_req_s) state_d = ST_GRANT;
                else if (!any_req_s)    state_d = HOLDA ? ST_RELEASE : ST_IDLE;
                else                    state_d = ST_HOLD_WAIT;
            end
            ST_GRANT: begin
                if (!HOLDA)                                              state_d = ST_CPU_GAP;
                else if (!owner_req_s || burst_cnt_q == CNT_W'(MAX_BURST - 1)) state_d = ST_TURN;
                else                                                     state_d = ST_GRANT;
            end
            ST_TURN: begin
                if (any_req_s && chain_cnt_q < CNT_W'(MAX_CHAIN)) state_d = ST_GRANT;
                else                                              state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!HOLDA) state_d = ST_CPU_GAP;
                else        state_d = ST_RELEASE;
            end
            ST_CPU_GAP: begin
                if (slot_cnt_q == CNT_W'(CPU_SLOT - 1)) state_d = ST_IDLE;
                else                                    state_d = ST_CPU_GAP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and counter next values, derived from the transition being taken.
    always_comb begin
        hold_d      = (state_d == ST_HOLD_WAIT) || (state_d == ST_GRANT) || (state_d == ST_TURN);
        busy_d      = (state_d != ST_IDLE);
        proto_err_d = (state_q == ST_GRANT) && !HOLDA;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        chain_cnt_d = chain_cnt_q;
        if (state_q == ST_GRANT) burst_cnt_d = sat_inc(burst_cnt_q);
        else                     burst_cnt_d = burst_cnt_q;
        if (grant_start_s) begin
            gnt_d       = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
            gnt_id_d    = winner_s;
            burst_cnt_d = {CNT_W{1'b0}};
            if (state_q == ST_TURN) chain_cnt_d = sat_inc(chain_cnt_q);
            else                    chain_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (state_d != ST_GRANT) begin
            gnt_d = {NUM_REQ{1'b0}};
        end else begin
            gnt_d = gnt_q;
        end
        if (state_q == ST_CPU_GAP)      slot_cnt_d = sat_inc(slot_cnt_q);
        else if (state_d == ST_CPU_GAP) slot_cnt_d = {CNT_W{1'b0}};
        else                            slot_cnt_d = slot_cnt_q;
    end

    assign HOLD      = hold_q;
    assign GNT       = gnt_q;
    assign GNT_ID    = gnt_id_q;
    assign BUSY      = busy_q;
    assign PROTO_ERR = proto_err_q;
endmodule

// File: tb/tb_bus_hold_arbiter.sv
// Self-checking bench for bus_hold_arbiter: directed scenarios plus randomized REQ/HOLDA
// against a behavioural model of the hold/grant rules.
module tb_bus_hold_arbiter;
    localparam int N         = 3;
    localparam int MAX_BURST = 16;
    localparam int MAX_CHAIN = 2;
    localparam int CPU_SLOT  = 8;
    localparam int IDW       = $clog2(N);

    logic           CLK = 1'b0;
    logic           RESET_n = 1'b0;
    logic [N-1:0]   REQ = '0;
    logic           HOLDA = 1'b0;
    logic           HOLD;
    logic [N-1:0]   GNT;
    logic [IDW-1:0] GNT_ID;
    logic           BUSY;
    logic           PROTO_ERR;

    int n_checks = 0;
    int n_errors = 0;

    typedef enum {P_IDLE, P_WAIT, P_OWN, P_TURN, P_REL, P_GAP} phase_e;
    phase_e m_ph = P_IDLE;
    int     m_owner = -1;
    int     m_len = 0, m_chain = 0, m_gap = 0, m_rr = 0, m_gnt_id = 0;
    bit     m_hold = 1'b0, m_perr = 1'b0;

    always #5 CLK = ~CLK;

    bus_hold_arbiter #(
        .NUM_REQ(N), .MAX_BURST(MAX_BURST), .MAX_CHAIN(MAX_CHAIN), .CPU_SLOT(CPU_SLOT)
    ) dut (
        .CLK(CLK), .RESET_n(RESET_n), .REQ(REQ), .HOLDA(HOLDA), .HOLD(HOLD),
        .GNT(GNT), .GNT_ID(GNT_ID), .BUSY(BUSY), .PROTO_ERR(PROTO_ERR)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit bit_of(input logic [N-1:0] v, input int i);
        logic [N-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    // Requester chosen by the arbitration rule in force.
    function automatic int model_pick(input logic [N-1:0] r);
        int start;
        start = 0;
`ifdef BUS_HOLD_ARB_ROUND_ROBIN_EN
        start = m_rr;
`endif
        for (int k = 0; k < N; k++)
            if (bit_of(r, (start + k) % N)) return (start + k) % N;
        return -1;
    endfunction

    task automatic model_grant(input logic [N-1:0] r);
        m_owner  = model_pick(r);
        m_gnt_id = m_owner;
        m_len    = 0;
        m_rr     = (m_owner + 1) % N;
        m_ph     = P_OWN;
    endtask

    // Advance the model by one clock edge with the inputs present at that edge.
    task automatic model_step(input logic [N-1:0] r, input logic h);
        m_perr = 1'b0;
        case (m_ph)
            P_IDLE: if (r != 0) begin m_ph = P_WAIT; m_hold = 1'b1; end
            P_WAIT: begin
                if (h && r != 0) begin model_grant(r); m_chain = 1; end
                else if (r == 0) begin m_hold = 1'b0; m_ph = h ? P_REL : P_IDLE; end
            end
            P_OWN: begin
                m_len++;
                if (!h) begin
                    m_owner = -1; m_perr = 1'b1; m_hold = 1'b0; m_gap = 0; m_ph = P_GAP;
                end else if (!bit_of(r, m_owner) || m_len == MAX_BURST) begin
                    m_owner = -1; m_ph = P_TURN;
                end
            end
            P_TURN: begin
                if (r != 0 && m_chain < MAX_CHAIN) begin model_grant(r); m_chain++; end
                else begin m_hold = 1'b0; m_ph = P_REL; end
            end
            P_REL: if (!h) begin m_gap = 0; m_ph = P_GAP; end
            P_GAP: begin
                m_gap++;
                if (m_gap == CPU_SLOT) m_ph = P_IDLE;
            end
            default: m_ph = P_IDLE;
        endcase
    endtask

    task automatic compare_outputs();
        logic [N-1:0] eg;
        eg = '0;
        if (m_owner >= 0) eg = {{(N-1){1'b0}}, 1'b1} << m_owner;
        check_eq("HOLD", 32'(HOLD), 32'(m_hold));
        check_eq("GNT", 32'(GNT), 32'(eg));
        check_eq("GNT_ID", 32'(GNT_ID), 32'(m_gnt_id));
        check_eq("BUSY", 32'(BUSY), 32'(m_ph != P_IDLE));
        check_eq("PROTO_ERR", 32'(PROTO_ERR), 32'(m_perr));
    endtask

    // One cycle: check outputs on the falling edge, then drive the next inputs.
    task automatic step(input logic [N-1:0] r, input logic h);
        @(negedge CLK);
        compare_outputs();
        REQ   = r;
        HOLDA = h;
        model_step(r, h);
    endtask

    task automatic apply_reset();
        RESET_n = 1'b0;
        REQ     = '0;
        HOLDA   = 1'b0;
        m_ph = P_IDLE; m_owner = -1; m_len = 0; m_chain = 0; m_gap = 0;
        m_rr = 0; m_gnt_id = 0; m_hold = 1'b0; m_perr = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_n = 1'b1;
        model_step('0, 1'b0);
    endtask

    task automatic grant_up(input logic [N-1:0] r);
        int i;
        i = 0;
        step(r, 1'b0);
        while (!HOLD && i < 20) begin
            step(r, 1'b0);
            i++;
        end
        check_eq("hold_up", 32'(HOLD), 32'd1);
        step(r, 1'b1);
        step(r, 1'b1);
    endtask

    initial begin
        int           g0, g1, low, mode;
        bit           seen;
        logic [N-1:0] r;
        logic         h;

        #1;
        check_eq("rst_hold", 32'(HOLD), 32'd0);
        check_eq("rst_gnt", 32'(GNT), 32'd0);
        check_eq("rst_gnt_id", 32'(GNT_ID), 32'd0);
        check_eq("rst_busy", 32'(BUSY), 32'd0);
        check_eq("rst_perr", 32'(PROTO_ERR), 32'd0);
        apply_reset();

        // Single master, HOLDA three cycles late, release and CPU gap.
        step(3'b001, 1'b0);
        repeat (3) step(3'b001, 1'b0);
        step(3'b001, 1'b1);
        step(3'b001, 1'b1);
        check_eq("s1_gnt", 32'(GNT), 32'd1);
        step(3'b000, 1'b1);
        step(3'b000, 1'b1);
        check_eq("s1_turn_gnt", 32'(GNT), 32'd0);
        check_eq("s1_turn_hold", 32'(HOLD), 32'd1);
        step(3'b000, 1'b1);
        check_eq("s1_rel_hold", 32'(HOLD), 32'd0);
        step(3'b000, 1'b0);
        low = 0;
        for (int i = 0; i < CPU_SLOT; i++) begin
            step(3'b001, 1'b0);
            if (!HOLD) low++;
        end
        check_eq("gap_low_cycles", 32'(low), 32'(CPU_SLOT));
        step(3'b001, 1'b0);
        check_eq("gap_idle_hold", 32'(HOLD), 32'd0);
        step(3'b001, 1'b0);
        check_eq("gap_rehold", 32'(HOLD), 32'd1);

        // HOLDA dropped during a grant.
        step(3'b001, 1'b1);
        step(3'b001, 1'b1);
        check_eq("pe_gnt_before", 32'(GNT), 32'd1);
        step(3'b001, 1'b0);
        step(3'b001, 1'b0);
        check_eq("pe_pulse", 32'(PROTO_ERR), 32'd1);
        check_eq("pe_gnt", 32'(GNT), 32'd0);
        check_eq("pe_hold", 32'(HOLD), 32'd0);
        step(3'b001, 1'b0);
        check_eq("pe_pulse_end", 32'(PROTO_ERR), 32'd0);

        // Request withdrawn before HOLDA.
        repeat (12) step(3'b000, 1'b0);
        step(3'b100, 1'b0);
        step(3'b000, 1'b0);
        check_eq("wd_hold_up", 32'(HOLD), 32'd1);
        step(3'b000, 1'b0);
        check_eq("wd_hold", 32'(HOLD), 32'd0);
        check_eq("wd_busy", 32'(BUSY), 32'd0);
        check_eq("wd_gnt", 32'(GNT), 32'd0);

        // Two masters requesting continuously: burst and chain limits.
        apply_reset();
        g0 = 0; g1 = 0; seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(3'b011, HOLD);
            if (GNT == 3'b001) g0++;
            if (GNT == 3'b010) g1++;
            if (GNT != 0) seen = 1'b1;
            if (seen && !HOLD) break;
        end
`ifdef BUS_HOLD_ARB_ROUND_ROBIN_EN
        check_eq("chain_g0", 32'(g0), 32'd16);
        check_eq("chain_g1", 32'(g1), 32'd16);
`else
        check_eq("chain_g0", 32'(g0), 32'd32);
        check_eq("chain_g1", 32'(g1), 32'd0);
`endif
        for (int i = 0; i < 40; i++) begin
            step(3'b011, HOLD);
            if (GNT != 0) break;
        end
        check_eq("next_first", 32'(GNT), 32'd1);

        // Asynchronous reset between clock edges while granted.
        apply_reset();
        grant_up(3'b001);
        step(3'b001, 1'b1);
        #2;
        RESET_n = 1'b0;
        #1;
        check_eq("ar_hold", 32'(HOLD), 32'd0);
        check_eq("ar_gnt", 32'(GNT), 32'd0);
        check_eq("ar_busy", 32'(BUSY), 32'd0);
        apply_reset();
        step(3'b001, 1'b0);
        step(3'b001, 1'b0);
        check_eq("ar_restart_hold", 32'(HOLD), 32'd1);
        check_eq("ar_restart_busy", 32'(BUSY), 32'd1);
        check_eq("ar_restart_gnt", 32'(GNT), 32'd0);

        // Randomized traffic with a lagging, occasionally misbehaving HOLDA.
        r = '0; mode = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 300 == 0) mode = $urandom_range(0, 2);
            if (mode == 0) begin
                for (int b = 0; b < N; b++)
                    if ($urandom_range(0, 7) == 0) r = r ^ ({{(N-1){1'b0}}, 1'b1} << b);
            end else if (mode == 1) begin
                r = '1;
            end else begin
                r = N'($urandom);
            end
            h = HOLDA;
            if (HOLDA != HOLD && $urandom_range(0, 2) == 0) h = HOLD;
            if (HOLDA && HOLD && $urandom_range(0, 199) == 0) h = 1'b0;
            step(r, h);
            if (c % 1000 == 999) begin
                #($urandom_range(1, 4));
                apply_reset();
            end
        end
        step('0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
